// File: rtl/dpd_decode_seq.sv
// dpd_decode_seq
//   Densely-packed-decimal (IEEE 754-2008 DPD) to BCD decoder with valid/ready
//   handshake. A word of N declets is latched on accept, then decoded LANES
//   declets per clock into a result register, then held until consumed.
//
// Parameters
//   N      declets per word (1..34)
//   LANES  declets decoded per clock (1..N, need not divide N)
//
// Ports
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   i_valid   input word present
//   i_ready   block can accept a word this cycle (IDLE and not in reset)
//   i         N declets, declet k at i[k*10+9:k*10]
//   o_valid   decoded word present on o (DONE)
//   o_ready   consumer accepts o this cycle
//   o         N*12 BCD bits, declet k at o[k*12+11:k*12], hundreds in top nibble
//   busy      decode in progress (RUN)
//   noncanon  sticky "some declet in the word is non-canonical"
//             (only with DPD_NONCANON_CHK_EN defined)
//
// Optional feature macro: DPD_NONCANON_CHK_EN

module dpd_decode_seq #(
  parameter int N     = 11,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [N*10-1:0]   i,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [N*12-1:0]   o,
  output logic              busy
`ifdef DPD_NONCANON_CHK_EN
  ,
  output logic              noncanon
`endif
);

  localparam int unsigned NU    = N;
  localparam int unsigned LU    = LANES;
  localparam int unsigned BEATS = (NU + LU - 1) / LU;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] beat;
  logic [9:0]    src      [NU];
  logic [11:0]   res      [NU];
  logic [9:0]    lane_in  [LU];
  logic [11:0]   lane_bcd [LU];
  logic          lane_ok  [LU];

  // Logic-based DPD decode, b[9:0] = p q r s t u v w x y.
  // Non-canonical codes fall into the b[6:5]=11 branch, which ignores b[9:8],
  // so they decode to the same digits as their canonical twin.
  function automatic logic [11:0] dpd2bcd(input logic [9:0] b);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    h = {1'b0, b[9:7]};
    t = {1'b0, b[6:4]};
    u = {1'b0, b[2:0]};
    if (b[3]) begin
      case (b[2:1])
        2'b00: u = {3'b100, b[0]};
        2'b01: begin
          t = {3'b100, b[4]};
          u = {1'b0, b[6:5], b[0]};
        end
        2'b10: begin
          h = {3'b100, b[7]};
          u = {1'b0, b[9:8], b[0]};
        end
        default: begin
          case (b[6:5])
            2'b00: begin
              h = {3'b100, b[7]};
              t = {3'b100, b[4]};
              u = {1'b0, b[9:8], b[0]};
            end
            2'b01: begin
              h = {3'b100, b[7]};
              t = {1'b0, b[9:8], b[4]};
              u = {3'b100, b[0]};
            end
            2'b10: begin
              t = {3'b100, b[4]};
              u = {3'b100, b[0]};
            end
            default: begin
              h = {3'b100, b[7]};
              t = {3'b100, b[4]};
              u = {3'b100, b[0]};
            end
          endcase
        end
      endcase
    end
    return {h, t, u};
  endfunction

  assign i_ready = (state == IDLE) && !rst;
  assign o_valid = (state == DONE);
  assign busy    = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_valid) state_nx = RUN;
      RUN:     if (beat == LAST_BEAT) state_nx = DONE;
      DONE:    if (o_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane l handles declet beat*LANES+l; lanes past N on the last beat stay off.
  always_comb begin
    for (int unsigned l = 0; l < LU; l++) begin
      lane_in[l] = '0;
      lane_ok[l] = 1'b0;
      for (int unsigned k = 0; k < NU; k++) begin
        if (k == 32'(beat) * LU + l) begin
          lane_in[l] = src[k];
          lane_ok[l] = 1'b1;
        end
      end
      lane_bcd[l] = dpd2bcd(lane_in[l]);
    end
  end

`ifdef DPD_NONCANON_CHK_EN
  function automatic logic is_noncanon(input logic [9:0] b);
    return (b[3:1] == 3'b111) && (b[6:5] == 2'b11) && (b[9:8] != 2'b00);
  endfunction

  logic beat_nc;

  always_comb begin
    beat_nc = 1'b0;
    for (int unsigned l = 0; l < LU; l++) begin
      if (lane_ok[l] && is_noncanon(lane_in[l])) beat_nc = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noncanon <= 1'b0;
    end else if (state == IDLE && i_valid) begin
      noncanon <= 1'b0;
    end else if (state == RUN && beat_nc) begin
      noncanon <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      for (int unsigned k = 0; k < NU; k++) begin
        src[k] <= '0;
        res[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            beat <= '0;
            for (int unsigned k = 0; k < NU; k++) src[k] <= i[k*10 +: 10];
          end
        end
        RUN: begin
          beat <= beat + 1'b1;
          for (int unsigned k = 0; k < NU; k++) begin
            if (k / LU == 32'(beat) && lane_ok[k % LU]) res[k] <= lane_bcd[k % LU];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o = '0;
    for (int unsigned k = 0; k < NU; k++) o[k*12 +: 12] = res[k];
  end

endmodule
